axis_ram_writer: RTL

//   Write-side counterpart of the AXI-Stream ROM reader: sinks an AXI-Stream of data words
//   and stores each frame sequentially into an internal RAM starting at address 0.

---
 rtl/kan_axis_pkg.sv | 21 ++
 rtl/axis_ram_writer_ram_simple_dp.sv | 30 +++
 rtl/axis_ram_writer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/kan_axis_pkg.sv
// Shared definitions for the KAN AXI-Stream table loaders: writer FSM states
// and the bit layout of the per-frame status word.
package kan_axis_pkg;

   typedef enum logic [1:0] {
      WRITE,
      DRAIN,
      DONE
   } wr_state_t;

   localparam int unsigned STAT_CNT_LSB = 0;

   function automatic int unsigned stat_err_bit(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic int unsigned stat_ovf_bit(input int unsigned addr_width);
      return addr_width + 2;
   endfunction

endpackage

// File: rtl/axis_ram_writer_ram_simple_dp.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Write-capable sibling of the table ROM primitive.
module ram_simple_dp #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Both ports in one process: a same-address read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_ram_writer.sv
// AXI-Stream sink that stores each frame into RAM from address 0 and reports count/overflow.
// Optional status stream enabled by defining AXIS_RAM_WRITER_STATUS_EN.
module axis_ram_writer
   import kan_axis_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_ack,
   output logic [ADDR_WIDTH:0]   wr_count,
   output logic                  frame_done,
`ifdef AXIS_RAM_WRITER_STATUS_EN
   output logic [ADDR_WIDTH+2:0] m_axis_status_tdata,
   output logic                  m_axis_status_tvalid,
   input  logic                  m_axis_status_tready,
`endif
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   wr_state_t             state;
   wr_state_t             next_state;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH:0]   count;
   logic                  done_first;
   logic                  beat;
   logic                  ram_we;

   assign s_axis_tready = !rst && (state != DONE);
   assign beat          = s_axis_tvalid && s_axis_tready;
   assign ram_we        = beat && (state == WRITE);
   assign frame_done    = done_first;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= WRITE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         WRITE: begin
            if (beat) begin
               if (s_axis_tlast) begin
                  next_state = DONE;
               end else if (wr_addr == '1) begin
                  next_state = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (beat && s_axis_tlast) begin
               next_state = DONE;
            end
         end
         DONE: begin
`ifdef AXIS_RAM_WRITER_STATUS_EN
            if (m_axis_status_tready) begin
               next_state = WRITE;
            end
`else
            next_state = WRITE;
`endif
         end
         default: next_state = WRITE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr    <= '0;
         count      <= '0;
         wr_count   <= '0;
         overflow   <= 1'b0;
         done_first <= 1'b0;
         rd_ack     <= 1'b0;
      end else begin
         rd_ack     <= rd_en;
         done_first <= (state != DONE) && (next_state == DONE);
         unique case (state)
            WRITE: begin
               if (beat) begin
                  // First beat of a frame clears the previous frame's sticky overflow.
                  if (wr_addr == '0) begin
                     overflow <= 1'b0;
                  end
                  if (s_axis_tlast) begin
                     count <= {1'b0, wr_addr} + (ADDR_WIDTH+1)'(1);
                  end else if (wr_addr == '1) begin
                     overflow <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (beat && s_axis_tlast) begin
                  count <= DEPTH_CNT;
               end
            end
            DONE: begin
               if (done_first) begin
                  wr_count <= count;
               end
               if (next_state == WRITE) begin
                  wr_addr <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AXIS_RAM_WRITER_STATUS_EN
   localparam int unsigned ERR_BIT = stat_err_bit(ADDR_WIDTH);
   localparam int unsigned OVF_BIT = stat_ovf_bit(ADDR_WIDTH);

   logic err;

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (beat) begin
         err <= err | (|s_axis_tuser);
      end else if ((state == DONE) && (next_state == WRITE)) begin
         err <= 1'b0;
      end
   end

   // All fields are frozen while DONE holds, so tdata is stable under backpressure.
   always_comb begin
      m_axis_status_tdata = '0;
      m_axis_status_tdata[STAT_CNT_LSB +: ADDR_WIDTH+1] = count;
      m_axis_status_tdata[ERR_BIT] = err;
      m_axis_status_tdata[OVF_BIT] = overflow;
   end

   assign m_axis_status_tvalid = (state == DONE);
`endif

   ram_simple_dp #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_ram (
      .clk    (clk),
      .wr_en  (ram_we),
      .wr_addr(wr_addr),
      .wr_data(s_axis_tdata),
      .rd_en  (rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

endmodule
